// File: rtl/decode_stage_if.sv
// Handshake bundles around the decode stage: fetch->decode request and decode->dispatch record.

interface decode_stage_in_if #(parameter int unsigned PC_W = 9);
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            ready;

    modport master (output instr, output pc, output valid, input  ready);
    modport slave  (input  instr, input  pc, input  valid, output ready);
endinterface

interface decode_stage_out_if #(parameter int unsigned PC_W = 9);
    logic            valid;
    logic            ready;
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [2:0]      cls;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic            illegal;

    modport master (output valid, input ready, output pc, output rs1, output rs2, output rd,
                    output imm, output cls, output alu_op, output funct3, output use_rs1,
                    output use_rs2, output wr_rd, output illegal);
    modport slave  (input valid, output ready, input pc, input rs1, input rs2, input rd,
                    input imm, input cls, input alu_op, input funct3, input use_rs1,
                    input use_rs2, input wr_rd, input illegal);
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: cracks one instruction per cycle into a single registered
// record slot with valid/ready flow control and redirect flush.

module decode_stage #(
    parameter int unsigned PC_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    decode_stage_in_if.slave   in_i,
    decode_stage_out_if.master out_o
);

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_LUI    = 3'd6,
        CLS_AUIPC  = 3'd7
    } cls_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        cls_e            cls;
        alu_e            alu_op;
        logic [2:0]      funct3;
        logic            use_rs1;
        logic            use_rs2;
        logic            wr_rd;
        logic            illegal;
    } rec_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // funct3 -> ALU op; alt selects SUB/SRA on the two funct3 values that have a variant
    function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_e op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic        valid_q, valid_d;
    rec_t        rec_q, rec_d;
    rec_t        dec_c;
    logic        in_ready_c;
    logic        accept_c;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins    = in_i.instr;
    assign opcode = ins[6:0];
    assign rd_f   = ins[11:7];
    assign f3     = ins[14:12];
    assign rs1_f  = ins[19:15];
    assign rs2_f  = ins[24:20];
    assign f7     = ins[31:25];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // Combinational crack of the incoming instruction into a full record
    always_comb begin
        logic use1, use2, wr, ill;
        logic [31:0] imm;
        cls_e        cls;
        alu_e        alu;

        use1 = 1'b0;
        use2 = 1'b0;
        wr   = 1'b0;
        ill  = 1'b0;
        imm  = '0;
        cls  = CLS_ALU;
        alu  = ALU_ADD;

        unique case (opcode)
            OPC_OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
                wr   = 1'b1;
                if (f7 == F7_BASE) begin
                    alu = alu_from_f3(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    alu = alu_from_f3(f3, 1'b1);
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                use1 = 1'b1;
                wr   = 1'b1;
                imm  = imm_i;
                alu  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
            end
            OPC_LOAD: begin
                cls  = CLS_LOAD;
                use1 = 1'b1;
                wr   = 1'b1;
                imm  = imm_i;
            end
            OPC_STORE: begin
                cls  = CLS_STORE;
                use1 = 1'b1;
                use2 = 1'b1;
                imm  = imm_s;
            end
            OPC_BRANCH: begin
                cls  = CLS_BRANCH;
                use1 = 1'b1;
                use2 = 1'b1;
                imm  = imm_b;
            end
            OPC_JAL: begin
                cls = CLS_JAL;
                wr  = 1'b1;
                imm = imm_j;
            end
            OPC_JALR: begin
                cls  = CLS_JALR;
                use1 = 1'b1;
                wr   = 1'b1;
                imm  = imm_i;
            end
            OPC_LUI: begin
                cls = CLS_LUI;
                wr  = 1'b1;
                imm = imm_u;
            end
            OPC_AUIPC: begin
                cls = CLS_AUIPC;
                wr  = 1'b1;
                imm = imm_u;
            end
            default: ill = 1'b1;
        endcase

        // An illegal encoding collapses to a harmless ALU record that touches no registers
        if (ill) begin
            use1 = 1'b0;
            use2 = 1'b0;
            wr   = 1'b0;
            imm  = '0;
            cls  = CLS_ALU;
            alu  = ALU_ADD;
        end

        dec_c         = '0;
        dec_c.pc      = in_i.pc;
        dec_c.funct3  = f3;
        dec_c.imm     = imm;
        dec_c.cls     = cls;
        dec_c.alu_op  = alu;
        dec_c.use_rs1 = use1;
        dec_c.use_rs2 = use2;
        dec_c.wr_rd   = wr && (rd_f != 5'd0);
        dec_c.illegal = ill;
        dec_c.rs1     = use1 ? rs1_f : 5'd0;
        dec_c.rs2     = use2 ? rs2_f : 5'd0;
        dec_c.rd      = (wr && (rd_f != 5'd0)) ? rd_f : 5'd0;
    end

    // Slot is free when empty or draining this cycle; redirect blocks intake
    assign in_ready_c = !flush && (!valid_q || out_o.ready);
    assign accept_c   = in_i.valid && in_ready_c;
    assign in_i.ready = in_ready_c;

    always_comb begin
        valid_d = valid_q;
        rec_d   = rec_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d = 1'b1;
            rec_d   = dec_c;
        end else if (out_o.ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
        end
    end

    assign out_o.valid   = valid_q;
    assign out_o.pc      = rec_q.pc;
    assign out_o.rs1     = rec_q.rs1;
    assign out_o.rs2     = rec_q.rs2;
    assign out_o.rd      = rec_q.rd;
    assign out_o.imm     = rec_q.imm;
    assign out_o.cls     = rec_q.cls;
    assign out_o.alu_op  = rec_q.alu_op;
    assign out_o.funct3  = rec_q.funct3;
    assign out_o.use_rs1 = rec_q.use_rs1;
    assign out_o.use_rs2 = rec_q.use_rs2;
    assign out_o.wr_rd   = rec_q.wr_rd;
    assign out_o.illegal = rec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic against a
// behavioural one-slot reference model.

module tb_decode_stage;

    localparam int unsigned PC_W = 9;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [2:0]      cls;
        logic [3:0]      alu;
        logic [2:0]      f3;
        logic            u1;
        logic            u2;
        logic            wr;
        logic            ill;
    } rec_t;

    logic clk;
    logic reset;
    logic flush;

    decode_stage_in_if  #(.PC_W(PC_W)) fi ();
    decode_stage_out_if #(.PC_W(PC_W)) di ();

    decode_stage #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .in_i  (fi),
        .out_o (di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;

    logic m_valid;
    logic m_fresh;
    rec_t m_rec;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference decode written from the ISA field definitions
    function automatic rec_t ref_decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        rec_t r;
        int   op, f3, f7, rd, rs1, rs2;
        int   cls;
        logic legal, u1, u2, wr;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [3:0]  tab [8];
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        op  = int'(ins & 32'h7F);
        rd  = int'((ins >> 7) & 32'h1F);
        f3  = int'((ins >> 12) & 32'h7);
        rs1 = int'((ins >> 15) & 32'h1F);
        rs2 = int'((ins >> 20) & 32'h1F);
        f7  = int'(ins >> 25);
        legal = 1'b1;
        imm = 32'd0;
        alu = 4'd0;
        cls = 0;
        case (op)
            'h33: begin
                cls = 0;
                if (f7 == 0) alu = tab[f3];
                else if (f7 == 'h20 && f3 == 0) alu = 4'd1;
                else if (f7 == 'h20 && f3 == 5) alu = 4'd7;
                else legal = 1'b0;
            end
            'h13: begin
                cls = 0;
                imm = 32'($signed(ins) >>> 20);
                alu = (f3 == 5 && ins[30]) ? 4'd7 : tab[f3];
            end
            'h03: begin cls = 1; imm = 32'($signed(ins) >>> 20); end
            'h23: begin cls = 2; imm = (32'($signed(ins) >>> 25) << 5) | 32'(rd); end
            'h63: begin
                cls = 3;
                imm = (32'(ins[7]) << 11) | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
                if (ins[31]) imm = imm | 32'hFFFFF000;
            end
            'h6F: begin
                cls = 4;
                imm = (((ins >> 21) & 32'h3FF) << 1) | (32'(ins[20]) << 11) | (((ins >> 12) & 32'hFF) << 12);
                if (ins[31]) imm = imm | 32'hFFF00000;
            end
            'h67: begin cls = 5; imm = 32'($signed(ins) >>> 20); end
            'h37: begin cls = 6; imm = ins & 32'hFFFFF000; end
            'h17: begin cls = 7; imm = ins & 32'hFFFFF000; end
            default: legal = 1'b0;
        endcase
        u1 = legal && !(cls == 4 || cls == 6 || cls == 7);
        u2 = legal && (op == 'h33 || cls == 2 || cls == 3);
        wr = legal && (cls == 0 || cls == 1 || cls >= 4) && rd != 0;
        if (!legal) begin
            imm = 32'd0;
            alu = 4'd0;
            cls = 0;
        end
        r.pc  = pc;
        r.rs1 = u1 ? 5'(rs1) : 5'd0;
        r.rs2 = u2 ? 5'(rs2) : 5'd0;
        r.rd  = wr ? 5'(rd) : 5'd0;
        r.imm = imm;
        r.cls = 3'(cls);
        r.alu = alu;
        r.f3  = 3'(f3);
        r.u1  = u1;
        r.u2  = u2;
        r.wr  = wr;
        r.ill = !legal;
        return r;
    endfunction

    task automatic check_outputs();
        logic exp_ready;
        exp_ready = !flush && (!m_valid || di.ready);
        check("in_ready", 32'(fi.ready), 32'(exp_ready));
        check("out_valid", 32'(di.valid), 32'(m_valid));
        if (m_valid || m_fresh) begin
            check("pc",      32'(di.pc),      32'(m_rec.pc));
            check("rs1",     32'(di.rs1),     32'(m_rec.rs1));
            check("rs2",     32'(di.rs2),     32'(m_rec.rs2));
            check("rd",      32'(di.rd),      32'(m_rec.rd));
            check("imm",     di.imm,          m_rec.imm);
            check("class",   32'(di.cls),     32'(m_rec.cls));
            check("alu_op",  32'(di.alu_op),  32'(m_rec.alu));
            check("funct3",  32'(di.funct3),  32'(m_rec.f3));
            check("use_rs1", 32'(di.use_rs1), 32'(m_rec.u1));
            check("use_rs2", 32'(di.use_rs2), 32'(m_rec.u2));
            check("wr_rd",   32'(di.wr_rd),   32'(m_rec.wr));
            check("illegal", 32'(di.illegal), 32'(m_rec.ill));
        end
    endtask

    // Advance the reference slot using the inputs that were present at this edge
    task automatic model_step();
        logic rdy;
        rdy = !flush && (!m_valid || di.ready);
        if (reset) begin
            m_valid = 1'b0;
            m_fresh = 1'b1;
            m_rec   = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (fi.valid && rdy) begin
            m_valid = 1'b1;
            m_fresh = 1'b0;
            m_rec   = ref_decode(fi.instr, fi.pc);
        end else if (m_valid && di.ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic ordy, input logic fl, input logic rs);
        fi.valid = v;
        fi.instr = ins;
        fi.pc    = pc;
        di.ready = ordy;
        flush    = fl;
        reset    = rs;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [9];
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r   = $urandom;
        sel = int'($urandom_range(0, 10));
        if (sel < 9) r[6:0] = ops[sel];
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0:       r[31:25] = 7'h00;
                1, 2:    r[31:25] = 7'h20;
                default: ;
            endcase
        end
        return r;
    endfunction

    initial begin
        fi.valid = 1'b0;
        fi.instr = '0;
        fi.pc    = '0;
        di.ready = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_fresh = 1'b1;
        m_rec   = '0;

        // reset state and first decode
        cycle(1'b1, 32'hFFF10093, 9'h010, 1'b1, 1'b0, 1'b0);
        check("addi_valid", 32'(di.valid), 32'd1);
        check("addi_class", 32'(di.cls), 32'd0);
        check("addi_rs1",   32'(di.rs1), 32'd2);
        check("addi_rd",    32'(di.rd), 32'd1);
        check("addi_imm",   di.imm, 32'hFFFFFFFF);
        check("addi_flags", {29'd0, di.use_rs1, di.use_rs2, di.wr_rd}, 32'b101);

        // back-to-back stream
        cycle(1'b1, 32'h402081B3, 9'h014, 1'b1, 1'b0, 1'b0);
        check("sub_alu", 32'(di.alu_op), 32'd1);
        check("sub_regs", {17'd0, di.rs1, di.rs2, di.rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        cycle(1'b1, 32'h00532423, 9'h018, 1'b1, 1'b0, 1'b0);
        check("sw_class", 32'(di.cls), 32'd2);
        check("sw_regs", {22'd0, di.rs1, di.rs2}, {22'd0, 5'd6, 5'd5});
        check("sw_imm", di.imm, 32'd8);
        check("sw_wr_f3", {28'd0, di.wr_rd, di.funct3}, {28'd0, 1'b0, 3'b010});
        cycle(1'b1, 32'hFE000EE3, 9'h01C, 1'b1, 1'b0, 1'b0);
        check("beq_class", 32'(di.cls), 32'd3);
        check("beq_imm", di.imm, 32'hFFFFFFFC);

        // backpressure: beq is held for three cycles
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h00500293, 9'h020, 1'b0, 1'b0, 1'b0);
            check("hold_imm", di.imm, 32'hFFFFFFFC);
            check("hold_pc", 32'(di.pc), 32'h01C);
        end
        cycle(1'b1, 32'h00500293, 9'h020, 1'b1, 1'b0, 1'b0);
        check("rel_pc", 32'(di.pc), 32'h020);
        check("rel_imm", di.imm, 32'd5);
        cycle(1'b0, 32'h0, 9'h0, 1'b1, 1'b0, 1'b0);
        check("drain_valid", 32'(di.valid), 32'd0);

        // flush with a held record and an incoming instruction
        cycle(1'b1, 32'hFFF10093, 9'h030, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081B3, 9'h034, 1'b0, 1'b1, 1'b0);
        check("flush_valid", 32'(di.valid), 32'd0);
        cycle(1'b0, 32'h0, 9'h0, 1'b1, 1'b0, 1'b0);
        check("flush_noacc", 32'(di.valid), 32'd0);

        // illegal encodings
        cycle(1'b1, 32'h00000000, 9'h040, 1'b1, 1'b0, 1'b0);
        check("ill0", {30'd0, di.illegal, di.wr_rd}, 32'b10);
        cycle(1'b1, 32'hFE0080B3, 9'h044, 1'b1, 1'b0, 1'b0);
        check("ill7f", 32'(di.illegal), 32'd1);

        // reset mid-hold
        cycle(1'b1, 32'hFFF10093, 9'h050, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h402081B3, 9'h054, 1'b0, 1'b0, 1'b1);
        check("rst_valid", 32'(di.valid), 32'd0);
        check("rst_imm", di.imm, 32'd0);
        check("rst_pc", 32'(di.pc), 32'd0);
        cycle(1'b1, 32'h402081B3, 9'h054, 1'b1, 1'b0, 1'b0);
        check("post_rst_alu", 32'(di.alu_op), 32'd1);
        check("post_rst_pc", 32'(di.pc), 32'h054);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), PC_W'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 149) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage sitting directly downstream of the fetch stage and upstream of rename/dispatch. It accepts one `{instr, pc}` pair per cycle over a valid/ready handshake. It cracks the instruction into register indices, a sign-extended immediate, an operation class and an ALU opcode, and holds the result in a single output register. The stage stalls under downstream backpressure and is flushed on branch redirect.

## Interface
- `PC_W`, default 9: width of the PC carried with each instruction.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  branch redirect; kills the held and the incoming instruction. Tied to the same signal that redirects fetch.
- `in_instr`  in  32  raw instruction from fetch.
- `in_pc`  in  PC_W  PC of `in_instr`.
- `in_valid`  in  1  fetch holds a valid instruction.
- `in_ready`  out  1  stage accepts this cycle. Drives the fetch stage's `ready`.
- `out_valid`  out  1  decoded record valid.
- `out_ready`  in  1  downstream consumes the record this cycle.
- `out_pc`  out  PC_W  PC of the decoded instruction.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices; 0 when unused.
- `out_imm`  out  32  sign-extended immediate; 0 for R-type.
- `out_class`  out  3  ALU=0, LOAD=1, STORE=2, BRANCH=3, JAL=4, JALR=5, LUI=6, AUIPC=7.
- `out_alu_op`  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- `out_funct3`  out  3  raw funct3, used for branch condition and load/store size.
- `out_use_rs1`, `out_use_rs2`, `out_wr_rd`  out  1 each  operand and destination usage flags.
- `out_illegal`  out  1  unsupported encoding.

## Operation
- Accept condition: `accept = in_valid && in_ready`.
  - `in_ready = !flush && (!out_valid || out_ready)`. This is combinational and passes through when the output slot drains in the same cycle.
- On accept: decode `in_instr` combinationally and load all `out_*` fields. Set `out_valid` to 1.
- Consume without accept: if `out_valid && out_ready` and there is no accept, `out_valid` goes to 0.
- Hold: if `out_valid && !out_ready`, all outputs stay stable. No field may change while held.
- Immediate formats, all sign-extended from bit 31:
  - I-type (OP-IMM, LOAD, JALR)
  - S-type (STORE)
  - B-type (BRANCH, bit 0 = 0)
  - U-type (LUI, AUIPC, low 12 bits = 0)
  - J-type (JAL, bit 0 = 0)
- ALU op selection:
  - OP (0110011): from funct3, with funct7[5] selecting SUB/SRA.
  - OP-IMM (0010011): from funct3. funct7[5] selects SRA for funct3=101 only. ADDI never produces SUB.
  - All other classes: ADD.
- Usage flags:
  - `use_rs1` = 1 except LUI, AUIPC and JAL.
  - `use_rs2` = 1 for OP, STORE and BRANCH.
  - `wr_rd` = 1 for ALU, LOAD, JAL, JALR, LUI and AUIPC, and only when rd ≠ 0.
- Unused register fields are output as 0.
- Illegal encodings:
  - Any opcode outside the eight RV32I classes above.
  - OP with funct7 ∉ {0x00, 0x20}.
  - funct7 = 0x20 with funct3 ∉ {000, 101}.
  - For illegal encodings: `illegal`=1, class=ALU, `wr_rd`=0, `use_rs1`=`use_rs2`=0, record still valid.
- Flush: `out_valid` goes to 0 on the next edge regardless of `out_ready`, and nothing is accepted that cycle. Data fields may keep stale values.

## Timing
- Reset: `out_valid`=0 and every `out_*` field = 0. `in_ready`=1 in the first cycle after reset (flush low).
- Latency: exactly 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- Accept and consume in the same cycle: the slot is replaced and `out_valid` stays 1.
- Flush and accept in the same cycle: not possible, because flush forces `in_ready`=0.
- Flush and `reset` together: reset wins. The result is identical either way.
- `out_ready` is ignored while `out_valid`=0.

## Test plan
- Reset, then `in_instr`=0xFFF10093 (addi x1,x2,-1), pc=0x010 → next cycle:
  - `out_valid`=1, class=0, alu=ADD, rs1=2, rd=1, imm=0xFFFFFFFF
  - `use_rs1`=1, `use_rs2`=0, `wr_rd`=1.
- Back-to-back stream with `out_ready`=1:
  - 0x402081B3 (sub x3,x1,x2) → alu=SUB, rs1=1, rs2=2, rd=3.
  - 0x00532423 (sw x5,8(x6)) → class=2, rs1=6, rs2=5, imm=8, `wr_rd`=0, funct3=010.
  - 0xFE000EE3 (beq x0,x0,-4) → class=3, imm=0xFFFFFFFC.
  - One result per cycle.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - `in_ready`=0 and outputs stable throughout.
  - On release, the held record is consumed. The next instruction appears the following cycle with no loss or duplication.
- Flush while holding a valid record and with `in_valid`=1:
  - next cycle `out_valid`=0 and the incoming instruction is not accepted.
- Illegal: 0x00000000 → `illegal`=1, `wr_rd`=0. Also 0xFE0080B3 (funct7=0x7F) → `illegal`=1.
- Reset asserted mid-hold with `out_valid`=1 → all outputs 0 the next cycle. The first post-reset accept decodes correctly.
